// File: rtl/arcade_input_ctrl_if.sv
// Player-input conditioner bus.
//   master : drives tick, joy_in, shared, af_en, af_rate; observes the outputs
//   slave  : the conditioner itself
//   tick      - time-base clock enable (single-cycle pulse)
//   joy_in    - raw joystick words, player p at [16p+15:16p]
//   shared    - player 0 directions/buttons drive every player slot
//   af_en     - autofire enable, bit [BUTTONS*p+b]
//   af_rate   - autofire half-period minus 1, in ticks
//   dir_out   - {up,down,left,right} per player
//   btn_out   - conditioned fire buttons
//   start_out - {start2,start1}, ORed across all players
//   coin_out  - shaped coin pulse per player
interface arcade_input_ctrl_if #(
  parameter int PLAYERS = 2,
  parameter int BUTTONS = 2
);
  logic                         tick;
  logic [16*PLAYERS-1:0]        joy_in;
  logic                         shared;
  logic [BUTTONS*PLAYERS-1:0]   af_en;
  logic [3:0]                   af_rate;
  logic [4*PLAYERS-1:0]         dir_out;
  logic [BUTTONS*PLAYERS-1:0]   btn_out;
  logic [1:0]                   start_out;
  logic [PLAYERS-1:0]           coin_out;

  modport master (
    output tick, joy_in, shared, af_en, af_rate,
    input  dir_out, btn_out, start_out, coin_out
  );

  modport slave (
    input  tick, joy_in, shared, af_en, af_rate,
    output dir_out, btn_out, start_out, coin_out
  );
endinterface

// File: rtl/arcade_input_ctrl.sv
// Player-input conditioner between hps_io joystick words and an arcade core.
// Routes directions/buttons (shared or per-player), cleans opposing
// directions, applies per-button autofire and shapes coin inputs into
// fixed-length pulses with a minimum gap. All outputs registered in clk_sys.
//   clk_sys - system clock
//   reset_n - asynchronous active-low reset
//   io      - arcade_input_ctrl_if slave (see interface header)
// Joystick word: [0] right, [1] left, [2] down, [3] up, [4+b] button b,
//   [4+BUTTONS] start1, [5+BUTTONS] start2, [6+BUTTONS] coin.
module arcade_input_ctrl #(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 2,
  parameter int COIN_LEN   = 8,
  parameter int SOCD_CLEAN = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  arcade_input_ctrl_if.slave io
);

  localparam int START1_BIT = 4 + BUTTONS;
  localparam int START2_BIT = 5 + BUTTONS;
  localparam int COIN_BIT   = 6 + BUTTONS;
  localparam logic [7:0] COIN_LAST = 8'(COIN_LEN - 1);

  typedef enum logic [1:0] {
    C_IDLE,
    C_PULSE,
    C_GAP,
    C_WAIT_REL
  } coin_state_t;

  logic [4*PLAYERS-1:0]       dir_nx;
  logic [BUTTONS*PLAYERS-1:0] btn_nx;
  logic [1:0]                 start_nx;
  logic [PLAYERS-1:0]         af_held;
  logic [PLAYERS-1:0]         af_ph;
  logic [PLAYERS-1:0]         coin_r;

  logic [4*PLAYERS-1:0]       dir_r;
  logic [BUTTONS*PLAYERS-1:0] btn_r;
  logic [1:0]                 start_r;

  // Routing, SOCD cleanup, autofire gating and start OR.
  always_comb begin
    logic [15:0]        word;
    logic [3:0]         d;
    logic [BUTTONS-1:0] b;
    logic [BUTTONS-1:0] en;
    int unsigned        sel;
    dir_nx   = '0;
    btn_nx   = '0;
    start_nx = '0;
    af_held  = '0;
    word     = '0;
    d        = '0;
    b        = '0;
    en       = '0;
    sel      = 0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      sel  = io.shared ? 0 : p;
      word = io.joy_in[16*sel +: 16];
      d    = word[3:0];
      if (SOCD_CLEAN != 0) begin
        if (d[0] && d[1]) d[1:0] = '0;
        if (d[2] && d[3]) d[3:2] = '0;
      end
      dir_nx[4*p +: 4] = d;
      b  = word[4 +: BUTTONS];
      en = io.af_en[BUTTONS*p +: BUTTONS];
      af_held[p] = |(b & en);
      btn_nx[BUTTONS*p +: BUTTONS] = b & (~en | {BUTTONS{af_ph[p]}});
      // Start is taken from every raw word regardless of shared routing.
      start_nx[0] = start_nx[0] | io.joy_in[16*p + START1_BIT];
      start_nx[1] = start_nx[1] | io.joy_in[16*p + START2_BIT];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir_r   <= '0;
      btn_r   <= '0;
      start_r <= '0;
    end else begin
      dir_r   <= dir_nx;
      btn_r   <= btn_nx;
      start_r <= start_nx;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    // Autofire phase: held at phase 1 while idle so the first press fires.
    logic [3:0] af_cnt;
    logic       af_ph_r;

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        af_cnt  <= '0;
        af_ph_r <= 1'b1;
      end else if (!af_held[p]) begin
        af_cnt  <= '0;
        af_ph_r <= 1'b1;
      end else if (io.tick) begin
        if (af_cnt == io.af_rate) begin
          af_cnt  <= '0;
          af_ph_r <= ~af_ph_r;
        end else begin
          af_cnt <= af_cnt + 4'd1;
        end
      end
    end

    assign af_ph[p] = af_ph_r;

    // Coin pulse shaper.
    logic        coin_live;
    logic        coin_prev;
    logic        coin_q;
    coin_state_t st, st_nx;
    logic [7:0]  cnt, cnt_nx;

    assign coin_live = io.joy_in[16*p + COIN_BIT];

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        st        <= C_IDLE;
        cnt       <= '0;
        coin_prev <= 1'b0;
        coin_q    <= 1'b0;
      end else begin
        st        <= st_nx;
        cnt       <= cnt_nx;
        coin_prev <= coin_live;
        coin_q    <= (st == C_PULSE);
      end
    end

    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      case (st)
        C_IDLE: begin
          if (coin_live && !coin_prev) begin
            st_nx  = C_PULSE;
            cnt_nx = '0;
          end
        end
        C_PULSE, C_GAP: begin
          if (io.tick) begin
            if (cnt == COIN_LAST) begin
              st_nx  = (st == C_PULSE) ? C_GAP : C_WAIT_REL;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt + 8'd1;
            end
          end
        end
        C_WAIT_REL: begin
          if (!coin_live) st_nx = C_IDLE;
        end
        default: st_nx = C_IDLE;
      endcase
    end

    assign coin_r[p] = coin_q;
  end

  assign io.dir_out   = dir_r;
  assign io.btn_out   = btn_r;
  assign io.start_out = start_r;
  assign io.coin_out  = coin_r;

endmodule
